pcnt_cfg_sequencer: RTL and testbench
=====================================

Name: pcnt_cfg_sequencer

Overview:
- Run-time configuration controller for the pulse-counter hard block.
- Accepts the 107-bit pcnt mode word as a stream of 32-bit words over a valid/ready port and assembles it in a shadow register.
- Quiesces the counter, commits the mode atomically, pulses the counter reset, then releases.
- Sits between the fabric/CPU config path and the pcnt_wrapper mode_i/stop_i/rst_i pins, replacing static CCFF configuration when run-time reprogramming is required.

Parameters:
- MODE_W, 107, width of the pcnt mode word.
- DATA_W, 32, config stream word width.
- STOP_CYCLES, 2, cycles stop is held before commit (drains the event pipeline); legal range 1..15.
- RESET_MODE, '0, value of mode_o after reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_valid_i  in  1  config word valid
- cfg_ready_o  out  1  config word accepted when valid&ready
- cfg_data_i  in  DATA_W  config word; word k maps to shadow bits [k*DATA_W +: DATA_W]
- cfg_last_i  in  1  marks final word of a load
- abort_i  in  1  discard a partial load
- ext_stop_i  in  1  user stop, ORed into pcnt_stop_o
- mode_o  out  MODE_W  committed mode to pcnt mode_i
- pcnt_stop_o  out  1  to pcnt stop_i
- pcnt_rst_o  out  1  active-high to pcnt rst_i
- busy_o  out  1  load/commit in progress
- done_o  out  1  one-cycle pulse on completed commit
- err_o  out  1  sticky framing error

Behaviour:
- Derived NWORDS = ceil(MODE_W/DATA_W) = 4 by default. Bits of the last word above MODE_W are ignored.
- Reset values (async, rst_ni low):
  - state=IDLE, word index=0, shadow=0, mode_o=RESET_MODE.
  - Internal stop=0, pcnt_rst_o=0, done_o=0, err_o=0.
- States:
  - IDLE: cfg_ready_o=1, busy_o=0. An accepted word writes slot 0 and moves to LOAD, index=1.
  - LOAD: cfg_ready_o=1, busy_o=1. Each accepted word writes slot[index] and increments index.
    - Accepted with cfg_last_i=1 and index==NWORDS-1 -> QUIESCE.
    - Framing error -> set err_o, discard load, index=0, go to IDLE; mode_o unchanged. A framing error is either:
      - cfg_last_i=1 on a word at index != NWORDS-1, or
      - cfg_last_i=0 on the word at index NWORDS-1.
    - abort_i=1 -> IDLE, index=0, no error. abort_i has priority over a same-cycle accept; that word is dropped.
  - QUIESCE: cfg_ready_o=0, internal stop=1. Hold for exactly STOP_CYCLES cycles, then go to COMMIT. abort_i is ignored.
  - COMMIT: 1 cycle. mode_o<=shadow (visible next cycle), pcnt_rst_o=1, internal stop=1, err_o cleared.
  - RESUME: 1 cycle. internal stop=0, pcnt_rst_o=0, done_o=1 -> IDLE.
- A single-word load (NWORDS=1) goes IDLE -> QUIESCE directly when cfg_last_i=1; cfg_last_i=0 is then an error.
- Latency:
  - Last accepted word to the mode_o update: STOP_CYCLES+1 cycles.
  - Last accepted word to done_o: STOP_CYCLES+2 cycles.
- Output timing:
  - pcnt_stop_o = internal stop | ext_stop_i, combinational from registered stop.
  - pcnt_rst_o and done_o are registered.
- mode_o never changes except in COMMIT; a partial shadow is never visible.
- rst_ni asserted mid-load or mid-quiesce: immediate return to reset values, mode_o=RESET_MODE.

Optional Feature:
- PCNT_CFG_READBACK_EN
  - Defined: adds ports rb_idx_i (in, clog2(NWORDS)) and rb_data_o (out, DATA_W). rb_data_o is a registered read of committed mode_o word rb_idx_i, 1-cycle latency, bits above MODE_W read 0, reset 0.
  - Undefined: the ports are absent and no readback logic is built.

Decomposition:
- Package pcnt_cfg_pkg holds:
  - state enum pcnt_cfg_state_e {IDLE, LOAD, QUIESCE, COMMIT, RESUME}.
  - Constants PCNT_MODE_W=107, PCNT_CFG_DATA_W=32, PCNT_CFG_NWORDS.
- One sub-module is natural: pcnt_cfg_shadow, the word-indexed shadow register bank with write-enable and index input. The FSM, timer and commit logic stay in the top.

Test Plan:
- Reset, then idle -> mode_o=0, cfg_ready_o=1, pcnt_stop_o=0, err_o=0.
- Load words 0x11111111, 0x22222222, 0x33333333, 0x7FFFF444 with last on word 3 -> pcnt_stop_o high for 3 cycles. After 3 cycles mode_o[31:0]=0x11111111 and mode_o[106:96]=0x444, pcnt_rst_o one pulse, done_o one pulse 4 cycles after the last accept.
- Back-to-back words with valid toggling each cycle -> identical mode_o; cfg_ready_o=0 throughout QUIESCE.
- cfg_last_i on word 1 -> err_o=1, mode_o keeps the previous value, no stop/rst pulse. A subsequent good load clears err_o.
- abort_i after 2 words, then a full load of 0xA5A5A5A5 x4 -> mode_o = all-A5 pattern truncated to 107 bits, err_o=0.
- rst_ni low during QUIESCE -> pcnt_stop_o drops asynchronously, mode_o=RESET_MODE. With PCNT_CFG_READBACK_EN, rb_idx_i=3 after the test-2 load returns 0x00000444.

Source files
------------

// File: rtl/pcnt_cfg_pkg.sv
// Shared constants, state encoding and helpers for the pulse-counter run-time config sequencer.
package pcnt_cfg_pkg;

   localparam int unsigned PCNT_MODE_W     = 107;
   localparam int unsigned PCNT_CFG_DATA_W = 32;
   localparam int unsigned PCNT_CFG_NWORDS =
      (PCNT_MODE_W + PCNT_CFG_DATA_W - 1) / PCNT_CFG_DATA_W;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      QUIESCE = 3'd2,
      COMMIT  = 3'd3,
      RESUME  = 3'd4
   } pcnt_cfg_state_e;

   // Word-index width, kept at least one bit so single-word builds still elaborate.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pcnt_cfg_shadow.sv
// Word-indexed shadow register bank that assembles the mode word from config stream words.
module pcnt_cfg_shadow
   import pcnt_cfg_pkg::*;
#(
   parameter int unsigned MODE_W = PCNT_MODE_W,
   parameter int unsigned DATA_W = PCNT_CFG_DATA_W,
   parameter int unsigned IDX_W  = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [MODE_W-1:0] shadow_o
);

   logic [MODE_W-1:0] shadow_q;

   // Only bits below MODE_W are stored; the excess of the final word is dropped here.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q <= '0;
      end else if (we_i) begin
         for (int unsigned b = 0; b < MODE_W; b++) begin
            if (idx_i == IDX_W'(b / DATA_W)) begin
               shadow_q[b] <= data_i[b % DATA_W];
            end
         end
      end
   end

   assign shadow_o = shadow_q;

endmodule

// File: rtl/pcnt_cfg_sequencer.sv
// Run-time mode loader for the pulse counter: assemble, quiesce, commit, reset pulse, release.
// Optional readback port of the committed mode is built when PCNT_CFG_READBACK_EN is defined.
module pcnt_cfg_sequencer
   import pcnt_cfg_pkg::*;
#(
   parameter int unsigned       MODE_W      = PCNT_MODE_W,
   parameter int unsigned       DATA_W      = PCNT_CFG_DATA_W,
   parameter int unsigned       STOP_CYCLES = 2,
   parameter logic [MODE_W-1:0] RESET_MODE  = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [DATA_W-1:0] cfg_data_i,
   input  logic              cfg_last_i,
   input  logic              abort_i,
   input  logic              ext_stop_i,
   output logic [MODE_W-1:0] mode_o,
   output logic              pcnt_stop_o,
   output logic              pcnt_rst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
`ifdef PCNT_CFG_READBACK_EN
   ,
   input  logic [idx_width((MODE_W+DATA_W-1)/DATA_W)-1:0] rb_idx_i,
   output logic [DATA_W-1:0]                              rb_data_o
`endif
);

   localparam int unsigned     NWORDS   = (MODE_W + DATA_W - 1) / DATA_W;
   localparam int unsigned     IDX_W    = idx_width(NWORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   pcnt_cfg_state_e   state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [3:0]        timer_q, timer_d;
   logic              err_q, err_d;
   logic              stop_q, rst_q, done_q;
   logic [MODE_W-1:0] mode_q;
   logic [MODE_W-1:0] shadow;
   logic              shadow_we;
   logic              accept;

   assign cfg_ready_o = (state_q == IDLE) || (state_q == LOAD);
   assign accept      = cfg_valid_i && cfg_ready_o;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      timer_d   = timer_q;
      err_d     = err_q;
      shadow_we = 1'b0;
      case (state_q)
         IDLE, LOAD: begin
            // Abort wins over a same-cycle accept; the offered word is dropped.
            if (abort_i) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (accept) begin
               shadow_we = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (cfg_last_i) begin
                     state_d = QUIESCE;
                     timer_d = 4'(STOP_CYCLES - 1);
                  end else begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                  end
               end else if (cfg_last_i) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  state_d = LOAD;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
         end
         QUIESCE: begin
            if (timer_q == 4'd0) begin
               state_d = COMMIT;
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         COMMIT: begin
            state_d = RESUME;
            err_d   = 1'b0;
         end
         RESUME:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         timer_q <= '0;
         err_q   <= 1'b0;
         stop_q  <= 1'b0;
         rst_q   <= 1'b0;
         done_q  <= 1'b0;
         mode_q  <= RESET_MODE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         timer_q <= timer_d;
         err_q   <= err_d;
         stop_q  <= (state_d == QUIESCE) || (state_d == COMMIT);
         rst_q   <= (state_d == COMMIT);
         done_q  <= (state_q == RESUME);
         if (state_q == COMMIT) begin
            mode_q <= shadow;
         end
      end
   end

   pcnt_cfg_shadow #(
      .MODE_W (MODE_W),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_shadow (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .we_i     (shadow_we),
      .idx_i    (idx_q),
      .data_i   (cfg_data_i),
      .shadow_o (shadow)
   );

   assign mode_o      = mode_q;
   assign pcnt_stop_o = stop_q | ext_stop_i;
   assign pcnt_rst_o  = rst_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign err_o       = err_q;

`ifdef PCNT_CFG_READBACK_EN
   logic [DATA_W-1:0] rb_d, rb_q;

   always_comb begin
      rb_d = '0;
      for (int unsigned w = 0; w < NWORDS; w++) begin
         if (rb_idx_i == IDX_W'(w)) begin
            for (int unsigned b = 0; b < DATA_W; b++) begin
               if (w * DATA_W + b < MODE_W) begin
                  rb_d[b] = mode_q[w*DATA_W+b];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rb_q <= '0;
      end else begin
         rb_q <= rb_d;
      end
   end

   assign rb_data_o = rb_q;
`endif

endmodule

// File: tb/tb_pcnt_cfg_sequencer.sv
// Self-checking bench for pcnt_cfg_sequencer: directed scenarios plus randomized loads,
// checked against a transaction-level model of the committed mode and error flag.
module tb_pcnt_cfg_sequencer;

   localparam int unsigned S = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cfg_valid, cfg_last, abort, ext_stop;
   logic [31:0]  cfg_data;
   logic         cfg_ready, pcnt_stop, pcnt_rst, busy, done, err;
   logic [106:0] mode;
`ifdef PCNT_CFG_READBACK_EN
   logic [1:0]   rb_idx;
   logic [31:0]  rb_data;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [106:0] model_mode = '0;
   logic         model_err  = 1'b0;

   always #5 clk = ~clk;

   pcnt_cfg_sequencer #(
      .STOP_CYCLES (S)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_data_i  (cfg_data),
      .cfg_last_i  (cfg_last),
      .abort_i     (abort),
      .ext_stop_i  (ext_stop),
      .mode_o      (mode),
      .pcnt_stop_o (pcnt_stop),
      .pcnt_rst_o  (pcnt_rst),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
`ifdef PCNT_CFG_READBACK_EN
      ,
      .rb_idx_i    (rb_idx),
      .rb_data_o   (rb_data)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] d, input logic l);
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_before_send: got %b want 1", cfg_ready);
      end
      cfg_valid = 1'b1;
      cfg_data  = d;
      cfg_last  = l;
      step();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      cfg_data  = '0;
   endtask

   // Observe the fixed commit timeline starting at the sample just after the last accept.
   task automatic check_commit(input logic [106:0] new_mode, input string name);
      logic [106:0] old_mode, exp_mode;
      logic [5:0]   got, exp;
      old_mode = model_mode;
      for (int k = 0; k <= S + 2; k++) begin
         exp = {((k <= S) ? 1'b1 : 1'b0) | ext_stop, (k == S), (k == S + 2),
                (k >= S + 2), (k <= S + 1), (k >= S + 1) ? 1'b0 : model_err};
         got = {pcnt_stop, pcnt_rst, done, cfg_ready, busy, err};
         exp_mode = (k >= S + 1) ? new_mode : old_mode;
         n_tests += 2;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s_ctrl k=%0d: {stop,rst,done,ready,busy,err} got %b want %b",
                     name, k, got, exp);
         end
         if (mode !== exp_mode) begin
            n_fail++;
            $display("FAIL %s_mode k=%0d: got %h want %h", name, k, mode, exp_mode);
         end
         if (k < S + 2) begin
            ext_stop = 1'($urandom);
            step();
         end
      end
      ext_stop   = 1'b0;
      model_mode = new_mode;
      model_err  = 1'b0;
   endtask

   task automatic good_load(input logic [127:0] words, input bit toggle, input string name);
      for (int i = 0; i < 4; i++) begin
         if (toggle && i > 0) step();
         send_word(words[i*32 +: 32], (i == 3));
      end
      check_commit(words[106:0], name);
   endtask

   task automatic bad_load(input int b, input string name);
      logic [5:0] got, exp;
      for (int i = 0; i <= b; i++) begin
         send_word($urandom, (b < 3) ? (i == b) : 1'b0);
      end
      model_err = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp = {ext_stop, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
         got = {pcnt_stop, pcnt_rst, done, cfg_ready, busy, err};
         n_tests += 2;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s_ctrl k=%0d: {stop,rst,done,ready,busy,err} got %b want %b",
                     name, k, got, exp);
         end
         if (mode !== model_mode) begin
            n_fail++;
            $display("FAIL %s_mode k=%0d: got %h want %h", name, k, mode, model_mode);
         end
         ext_stop = 1'($urandom);
         step();
      end
      ext_stop = 1'b0;
   endtask

   task automatic abort_load(input int n, input string name);
      logic [2:0] got, exp;
      for (int i = 0; i < n; i++) send_word($urandom, 1'b0);
      abort     = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = $urandom;
      cfg_last  = 1'($urandom);
      step();
      abort     = 1'b0;
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      exp = {1'b1, 1'b0, model_err};
      got = {cfg_ready, busy, err};
      n_tests += 2;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s_state: {ready,busy,err} got %b want %b", name, got, exp);
      end
      if (mode !== model_mode) begin
         n_fail++;
         $display("FAIL %s_mode: got %h want %h", name, mode, model_mode);
      end
   endtask

`ifdef PCNT_CFG_READBACK_EN
   task automatic rb_check(input logic [1:0] idx);
      logic [127:0] pad;
      logic [31:0]  exp;
      pad    = {21'b0, model_mode};
      exp    = pad[idx*32 +: 32];
      rb_idx = idx;
      step();
      n_tests++;
      if (rb_data !== exp) begin
         n_fail++;
         $display("FAIL readback idx=%0d: got %h want %h", idx, rb_data, exp);
      end
   endtask
`endif

   task automatic test_reset();
      logic [6:0] got;
      rst_n = 1'b0;
      #12;
      got = {cfg_ready, pcnt_stop, pcnt_rst, done, err, busy, |mode};
      n_tests++;
      if (got !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_during: got %b want 1000000", got);
      end
      #5 rst_n = 1'b1;
      step();
      got = {cfg_ready, pcnt_stop, pcnt_rst, done, err, busy, |mode};
      n_tests++;
      if (got !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_idle: got %b want 1000000", got);
      end
   endtask

   task automatic test_basic_load();
      good_load({32'h7FFFF444, 32'h33333333, 32'h22222222, 32'h11111111}, 1'b0, "basic");
      n_tests++;
      if (mode[31:0] !== 32'h11111111 || mode[106:96] !== 11'h444) begin
         n_fail++;
         $display("FAIL basic_fields: low %h high %h want 11111111 444",
                  mode[31:0], mode[106:96]);
      end
`ifdef PCNT_CFG_READBACK_EN
      rb_check(2'd3);
      rb_check(2'd0);
`endif
   endtask

   task automatic test_back_to_back();
      good_load({32'h7FFFF444, 32'h33333333, 32'h22222222, 32'h11111111}, 1'b1, "toggle");
      good_load({$urandom, $urandom, $urandom, $urandom}, 1'b0, "b2b_a");
      good_load({$urandom, $urandom, $urandom, $urandom}, 1'b0, "b2b_b");
   endtask

   task automatic test_framing_error();
      bad_load(1, "err_last1");
      good_load({$urandom, $urandom, $urandom, $urandom}, 1'b0, "err_recover");
      bad_load(3, "err_nolast");
      good_load({$urandom, $urandom, $urandom, $urandom}, 1'b1, "err_recover2");
   endtask

   task automatic test_abort();
      abort_load(2, "abort2");
      good_load({4{32'hA5A5A5A5}}, 1'b0, "after_abort");
   endtask

   task automatic test_reset_quiesce();
      logic [6:0] got;
      bad_load(2, "pre_rst_err");
      for (int i = 0; i < 4; i++) send_word($urandom, (i == 3));
      #2 rst_n = 1'b0;
      #1;
      got = {pcnt_stop, pcnt_rst, done, err, busy, cfg_ready, |mode};
      n_tests++;
      if (got !== 7'b0000010) begin
         n_fail++;
         $display("FAIL rst_quiesce: {stop,rst,done,err,busy,ready,|mode} got %b want 0000010",
                  got);
      end
      #2 rst_n = 1'b1;
      step();
      model_mode = '0;
      model_err  = 1'b0;
      n_tests++;
      if (mode !== '0 || err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_release: mode %h err %b busy %b want 0 0 0", mode, err, busy);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         case ($urandom_range(0, 3))
            0: bad_load(int'($urandom_range(1, 3)), "rnd_err");
            1: abort_load(int'($urandom_range(1, 3)), "rnd_abort");
            default: good_load({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), "rnd_load");
         endcase
`ifdef PCNT_CFG_READBACK_EN
         rb_check(2'($urandom));
`endif
      end
   endtask

   initial begin
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      cfg_data  = '0;
      abort     = 1'b0;
      ext_stop  = 1'b0;
`ifdef PCNT_CFG_READBACK_EN
      rb_idx    = '0;
`endif
      test_reset();
      test_basic_load();
      test_back_to_back();
      test_framing_error();
      test_abort();
      test_reset_quiesce();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
